// File: rtl/sn76489_register_interface.sv
// SN76489 PSG register interface.
// Decodes CPU byte writes into the tone/attenuation/noise registers and
// generates the generator enable tick and the noise LFSR reload pulse.
// Ports:
//   clk, reset_n      : clock and synchronous active-low reset
//   wr, data[7:0]     : CPU write strobe and byte
//   tone0_n..tone2_n  : 10-bit tone half-periods
//   noise_n, noise_fb : noise shift period and feedback type (1 = white)
//   att0..att3        : 4-bit attenuations (att3 = noise channel)
//   noise_rst         : one-cycle pulse after any noise-register write
//   enable            : one-cycle tick every CLK_DIV clocks
module sn76489_register_interface #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr,
    input  logic [7:0] data,
    output logic [9:0] tone0_n,
    output logic [9:0] tone1_n,
    output logic [9:0] tone2_n,
    output logic [9:0] noise_n,
    output logic       noise_fb,
    output logic [3:0] att0,
    output logic [3:0] att1,
    output logic [3:0] att2,
    output logic [3:0] att3,
    output logic       noise_rst,
    output logic       enable
);

    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TONE_W  = 10;
    localparam int unsigned ATT_W   = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [TONE_W-1:0] tone0_q, tone0_d, tone1_q, tone1_d, tone2_q, tone2_d;
    logic [ATT_W-1:0]  att0_q, att0_d, att1_q, att1_d, att2_q, att2_d, att3_q, att3_d;
    logic              noise_fb_q, noise_fb_d;
    logic [1:0]        rate_q, rate_d;
    logic [1:0]        latch_ch_q, latch_ch_d;
    logic              latch_vol_q, latch_vol_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              noise_rst_q, noise_rst_d;
    logic              enable_q, enable_d;

    logic [1:0]        tgt_ch;
    logic              tgt_vol;
    logic              is_latch;

    // Next-state decode for register writes and the enable divider.
    always_comb begin
        tone0_d     = tone0_q;
        tone1_d     = tone1_q;
        tone2_d     = tone2_q;
        att0_d      = att0_q;
        att1_d      = att1_q;
        att2_d      = att2_q;
        att3_d      = att3_q;
        noise_fb_d  = noise_fb_q;
        rate_d      = rate_q;
        latch_ch_d  = latch_ch_q;
        latch_vol_d = latch_vol_q;
        noise_rst_d = 1'b0;
        is_latch    = data[7];
        tgt_ch      = latch_ch_q;
        tgt_vol     = latch_vol_q;

        // Enable is registered, so it is computed from the next divider value.
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        enable_d = (div_d == DIV_LAST);

        if (wr) begin
            // A latch byte retargets first, then writes its low nibble.
            if (is_latch) begin
                tgt_ch      = data[6:5];
                tgt_vol     = data[4];
                latch_ch_d  = data[6:5];
                latch_vol_d = data[4];
            end

            if (tgt_vol) begin
                case (tgt_ch)
                    2'd0:    att0_d = data[3:0];
                    2'd1:    att1_d = data[3:0];
                    2'd2:    att2_d = data[3:0];
                    default: att3_d = data[3:0];
                endcase
            end else if (tgt_ch == 2'd3) begin
                noise_fb_d  = data[2];
                rate_d      = data[1:0];
                noise_rst_d = 1'b1;
            end else begin
                case (tgt_ch)
                    2'd0: begin
                        if (is_latch) tone0_d[3:0] = data[3:0];
                        else          tone0_d[9:4] = data[5:0];
                    end
                    2'd1: begin
                        if (is_latch) tone1_d[3:0] = data[3:0];
                        else          tone1_d[9:4] = data[5:0];
                    end
                    default: begin
                        if (is_latch) tone2_d[3:0] = data[3:0];
                        else          tone2_d[9:4] = data[5:0];
                    end
                endcase
            end
        end
    end

    // State registers; a write in a reset cycle is dropped by the reset branch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tone0_q     <= '0;
            tone1_q     <= '0;
            tone2_q     <= '0;
            att0_q      <= 4'hF;
            att1_q      <= 4'hF;
            att2_q      <= 4'hF;
            att3_q      <= 4'hF;
            noise_fb_q  <= 1'b0;
            rate_q      <= 2'b00;
            latch_ch_q  <= 2'd0;
            latch_vol_q <= 1'b0;
            div_q       <= '0;
            noise_rst_q <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            tone0_q     <= tone0_d;
            tone1_q     <= tone1_d;
            tone2_q     <= tone2_d;
            att0_q      <= att0_d;
            att1_q      <= att1_d;
            att2_q      <= att2_d;
            att3_q      <= att3_d;
            noise_fb_q  <= noise_fb_d;
            rate_q      <= rate_d;
            latch_ch_q  <= latch_ch_d;
            latch_vol_q <= latch_vol_d;
            div_q       <= div_d;
            noise_rst_q <= noise_rst_d;
            enable_q    <= enable_d;
        end
    end

    // Noise period from registered rate; rate 3 tracks tone2 with no extra delay.
    always_comb begin
        noise_n = 10'h010;
        case (rate_q)
            2'b00:   noise_n = 10'h010;
            2'b01:   noise_n = 10'h020;
            2'b10:   noise_n = 10'h040;
            default: noise_n = tone2_q;
        endcase
    end

    assign tone0_n   = tone0_q;
    assign tone1_n   = tone1_q;
    assign tone2_n   = tone2_q;
    assign att0      = att0_q;
    assign att1      = att1_q;
    assign att2      = att2_q;
    assign att3      = att3_q;
    assign noise_fb  = noise_fb_q;
    assign noise_rst = noise_rst_q;
    assign enable    = enable_q;

endmodule
